// File: rtl/blink_monitor.sv
// blink_monitor: measures a slow square wave on an asynchronous input.
// The input is synchronized, optionally glitch-filtered, and edge-detected.
// Each full cycle after arming is reported as (high time, period) in clock cycles
// through a one-entry valid/ready output register.
// Optional feature macro: BLINK_MONITOR_GLITCH_FILTER_EN (adds a stability filter
// after the synchronizer; when undefined, FILTER_CYCLES has no effect).

module blink_monitor #(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sense,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] period_cycles,
    output logic             overrun,
    output logic             timeout,
    output logic             level
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], sense};
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift the raw line through the synchronizer chain.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of statement order.
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional glitch filter
    // ------------------------------------------------------------------
    logic lvl;

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FILT_W-1:0] STAB_LAST = FILT_W'(FILTER_CYCLES - 1);

    logic [FILT_W-1:0] stab_q;
    logic [FILT_W-1:0] stab_d;
    logic              filt_q;
    logic              filt_d;

    // Accept a new level only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        stab_d = '0;
        filt_d = filt_q;
        if (sync_out != filt_q) begin
            if (stab_q == STAB_LAST) begin
                filt_d = sync_out;
            end else begin
                stab_d = stab_q + FILT_W'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stab_q <= '0;
            filt_q <= 1'b0;
        end else begin
            stab_q <= stab_d;
            filt_q <= filt_d;
        end
    end

    assign lvl = filt_q;
`else
    // FILTER_CYCLES only shapes the filter, which this build does not contain.
    logic unused_filter_cfg;
    assign unused_filter_cfg = (FILTER_CYCLES != 0);

    assign lvl = sync_out;
`endif

    assign level = lvl;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic lvl_prev_q;
    logic rise;
    logic fall;

    assign rise = lvl & ~lvl_prev_q;
    assign fall = ~lvl & lvl_prev_q;

    // Delayed copy of the filtered level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            lvl_prev_q <= 1'b0;
        end else begin
            lvl_prev_q <= lvl;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM and phase counter
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_tmp_q;
    logic [CNT_W-1:0] hi_tmp_d;
    logic             cnt_max;
    logic             complete;
    logic             timeout_q;
    logic             timeout_d;

    assign cnt_max = (cnt_q == CNT_MAX);
    // Saturating increment: a counter parked at its maximum never wraps, which
    // guarantees the timeout path is taken instead of a bogus small count.
    assign cnt_inc = cnt_max ? cnt_q : (cnt_q + CNT_ONE);

    // Next-state, counter and completion decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_tmp_d  = hi_tmp_q;
        complete  = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The cycle in progress when we arm is never reported.
                if (rise) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    hi_tmp_d = cnt_q;
                    cnt_d    = cnt_inc;
                    state_d  = ST_LOW;
                end else if (cnt_max) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_LOW: begin
                if (rise) begin
                    complete = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = ST_HIGH;
                end else if (cnt_max) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counter and timeout pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_tmp_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_tmp_q  <= hi_tmp_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

    // ------------------------------------------------------------------
    // One-entry result register with valid/ready handshake
    // ------------------------------------------------------------------
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] high_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             load;
    logic             drop;

    // A completion loads when the slot is empty or is being emptied this cycle;
    // otherwise the held result wins and the new one is lost.
    assign load = complete & (~valid_q | meas_ready);
    assign drop = complete & valid_q & ~meas_ready;

    // Result register next-state.
    always_comb begin
        valid_d   = valid_q;
        high_d    = high_q;
        period_d  = period_q;
        overrun_d = overrun_q | drop;

        if (load) begin
            valid_d  = 1'b1;
            high_d   = hi_tmp_q;
            period_d = cnt_q;
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result register state.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            high_q    <= '0;
            period_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            high_q    <= high_d;
            period_q  <= period_d;
            overrun_q <= overrun_d;
        end
    end

    assign meas_valid    = valid_q;
    assign high_cycles   = high_q;
    assign period_cycles = period_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Self-checking bench for blink_monitor: reset values, a table of steady waves,
// hand-written backpressure / timeout / reset / glitch sequences, and a random
// wave checked against a phase-length model (high = H, period = H + L).

module tb_blink_monitor;

    localparam int CNT_W         = 8;
    localparam int SYNC_STAGES   = 2;
    localparam int FILTER_CYCLES = 4;
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    localparam int MIN_PHASE = FILTER_CYCLES;
`else
    localparam int MIN_PHASE = 1;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             sense = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] period_cycles;
    logic             overrun;
    logic             timeout;
    logic             level;

    blink_monitor #(
        .CNT_W        (CNT_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sense        (sense),
        .meas_ready   (meas_ready),
        .meas_valid   (meas_valid),
        .high_cycles  (high_cycles),
        .period_cycles(period_cycles),
        .overrun      (overrun),
        .timeout      (timeout),
        .level        (level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] per;
    } rep_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_high;
        int exp_period;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   tmo_cycles = 0;
    rep_t obs_q[$];
    rep_t exp_q[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: records transfers, counts timeout pulses, and checks that a
    // stalled result stays put.
    initial begin
        logic             prev_hold;
        logic [CNT_W-1:0] prev_high;
        logic [CNT_W-1:0] prev_per;
        prev_hold = 1'b0;
        prev_high = '0;
        prev_per  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(meas_valid), 1);
                    check("hold_data", 32'({high_cycles, period_cycles}),
                          32'({prev_high, prev_per}));
                end
                if (timeout) tmo_cycles++;
                if (meas_valid && meas_ready) obs_q.push_back('{high_cycles, period_cycles});
                prev_hold = meas_valid && !meas_ready;
                prev_high = high_cycles;
                prev_per  = period_cycles;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sense = 1'b0;
        step(2);
        reset = 1'b0;
        obs_q.delete();
        tmo_cycles = 0;
    endtask

    task automatic wave(input int h, input int l);
        sense = 1'b1;
        step(h);
        sense = 1'b0;
        step(l);
    endtask

    task automatic expect_report(input string name, input int hi, input int per);
        rep_t r;
        if (obs_q.size() == 0) begin
            check({name, "_present"}, 0, 1);
        end else begin
            r = obs_q.pop_front();
            check({name, "_high"}, 32'(r.hi), hi);
            check({name, "_period"}, 32'(r.per), per);
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   h;
        int   l;
        int   ph;
        int   pl;
        int   n_exp;
        rep_t e;

        vecs[0] = '{10, 6, 3, 10, 16};
        vecs[1] = '{1, 1, 4, 1, 2};
        vecs[2] = '{3, 7, 3, 3, 10};
        vecs[3] = '{200, 55, 2, 200, 255};
        vecs[4] = '{5, 1, 3, 5, 6};

        // ---------------- reset values ----------------
        do_reset();
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_high", 32'(high_cycles), 0);
        check("rst_period", 32'(period_cycles), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_level", 32'(level), 0);

        // ---------------- table of steady waves ----------------
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].hi < MIN_PHASE || vecs[i].lo < MIN_PHASE) continue;
            do_reset();
            meas_ready = 1'b1;
            repeat (vecs[i].reps) wave(vecs[i].hi, vecs[i].lo);
            sense = 1'b1;
            step(vecs[i].hi);
            sense = 1'b0;
            step(20);
            check($sformatf("vec%0d_count", i), obs_q.size(), vecs[i].reps);
            for (int k = 0; k < vecs[i].reps; k++)
                expect_report($sformatf("vec%0d_rep%0d", i, k), vecs[i].exp_high, vecs[i].exp_period);
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 0);
            check($sformatf("vec%0d_timeout", i), tmo_cycles, 0);
        end

        // ---------------- backpressure ----------------
        do_reset();
        meas_ready = 1'b0;
        wave(10, 6);
        check("bp_partial_not_reported", 32'(meas_valid), 0);
        wave(10, 6);
        check("bp_first_valid", 32'(meas_valid), 1);
        check("bp_first_high", 32'(high_cycles), 10);
        check("bp_first_period", 32'(period_cycles), 16);
        check("bp_no_overrun_yet", 32'(overrun), 0);
        wave(10, 6);
        check("bp_overrun_set", 32'(overrun), 1);
        sense = 1'b1;
        step(10);
        sense = 1'b0;
        step(10);
        check("bp_held_high", 32'(high_cycles), 10);
        check("bp_held_period", 32'(period_cycles), 16);
        meas_ready = 1'b1;
        step(6);
        check("bp_one_transfer", obs_q.size(), 1);
        expect_report("bp_transfer", 10, 16);
        check("bp_valid_cleared", 32'(meas_valid), 0);
        check("bp_overrun_sticky", 32'(overrun), 1);

        // ---------------- timeout (counter saturation) ----------------
        do_reset();
        meas_ready = 1'b1;
        sense = 1'b1;
        step(300);
        check("tmo_pulse_cycles", tmo_cycles, 1);
        check("tmo_no_valid", 32'(meas_valid), 0);
        check("tmo_no_report", obs_q.size(), 0);
        sense = 1'b0;
        step(6);
        wave(10, 6);
        wave(10, 6);
        check("tmo_rearm_count", obs_q.size(), 1);
        expect_report("tmo_rearm", 10, 16);
        check("tmo_still_one", tmo_cycles, 1);

        // ---------------- reset mid-operation ----------------
        do_reset();
        meas_ready = 1'b0;
        wave(10, 6);
        wave(10, 6);
        sense = 1'b1;
        step(10);
        sense = 1'b0;
        step(3);
        check("mid_pre_valid", 32'(meas_valid), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_valid", 32'(meas_valid), 0);
        check("mid_high", 32'(high_cycles), 0);
        check("mid_period", 32'(period_cycles), 0);
        check("mid_overrun", 32'(overrun), 0);
        check("mid_timeout", 32'(timeout), 0);
        check("mid_level", 32'(level), 0);
        meas_ready = 1'b1;
        step(5);
        wave(10, 6);
        check("mid_after_one_rise", obs_q.size(), 0);
        wave(10, 6);
        check("mid_after_two_rises", obs_q.size(), 1);
        expect_report("mid_report", 10, 16);

        // ---------------- glitch inside a 20-cycle high phase ----------------
        do_reset();
        meas_ready = 1'b1;
        repeat (2) begin
            sense = 1'b1;
            step(9);
            sense = 1'b0;
            step(2);
            sense = 1'b1;
            step(1);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
            check("glitch_level_held", 32'(level), 1);
`endif
            step(8);
            sense = 1'b0;
            step(6);
        end
        sense = 1'b1;
        step(9);
        sense = 1'b0;
        step(20);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
        check("glitch_count", obs_q.size(), 2);
        expect_report("glitch_r0", 20, 26);
        expect_report("glitch_r1", 20, 26);
`else
        check("glitch_count", obs_q.size(), 4);
        expect_report("glitch_r0", 9, 11);
        expect_report("glitch_r1", 9, 15);
        expect_report("glitch_r2", 9, 11);
        expect_report("glitch_r3", 9, 15);
`endif

        // ---------------- random waves vs phase model ----------------
        do_reset();
        meas_ready = 1'b1;
        exp_q.delete();
        ph = 0;
        pl = 0;
        for (int k = 0; k < 40; k++) begin
            h = int'($urandom_range(60, MIN_PHASE));
            l = int'($urandom_range(60, MIN_PHASE));
            // Each new rise completes the previous full cycle.
            if (k > 0) exp_q.push_back('{CNT_W'(ph), CNT_W'(ph + pl)});
            wave(h, l);
            ph = h;
            pl = l;
        end
        exp_q.push_back('{CNT_W'(ph), CNT_W'(ph + pl)});
        sense = 1'b1;
        step(MIN_PHASE + 4);
        sense = 1'b0;
        step(20);
        n_exp = exp_q.size();
        check("rand_count", obs_q.size(), n_exp);
        for (int k = 0; k < n_exp; k++) begin
            e = exp_q.pop_front();
            expect_report($sformatf("rand%0d", k), 32'(e.hi), 32'(e.per));
        end
        check("rand_overrun", 32'(overrun), 0);
        check("rand_timeout", tmo_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
